// File: rtl/ysyx_23060077_riscv_imem_pkg.sv
// Types and constants shared by the instruction memory front end.
`include "ysyx_23060077_riscv_define.v"

package ysyx_23060077_riscv_imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `IMEM_ST_IDLE,
    ST_WAIT = `IMEM_ST_WAIT,
    ST_RESP = `IMEM_ST_RESP
  } imem_state_e;

  localparam logic [`INST_WIDTH-1:0] IMEM_NOP_WORD = `IMEM_NOP;
  localparam int IMEM_CNT_W = 4;

endpackage

// File: rtl/ysyx_23060077_riscv_imem_if.sv
// Fetch request/response channel between the fetcher (master) and the imem (slave).
`include "ysyx_23060077_riscv_define.v"

interface ysyx_23060077_riscv_imem_if;
  logic                   req_valid;
  logic                   req_ready;
  logic [`DATA_WIDTH-1:0] req_addr;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [`INST_WIDTH-1:0] rsp_inst;
  logic                   rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_23060077_riscv_define.v
// Shared widths, constants and fetch FSM state encodings for the ysyx_23060077 core.
`ifndef YSYX_23060077_RISCV_DEFINE_V
`define YSYX_23060077_RISCV_DEFINE_V

`define DATA_WIDTH   32
`define INST_WIDTH   32
`define IMEM_NOP     32'h0000_0013

`define IMEM_ST_IDLE 2'd0
`define IMEM_ST_WAIT 2'd1
`define IMEM_ST_RESP 2'd2

`endif

// File: rtl/ysyx_23060077_riscv_imem_ram.sv
// Word-wide instruction storage: one synchronous write port, one synchronous read port.
module ysyx_23060077_riscv_imem_ram #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read register sees the pre-write word on a same-edge collision; only it is reset.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ysyx_23060077_riscv_imem.sv
// Instruction memory front end: single-outstanding fetch FSM around a preloadable RAM.
// Build option YSYX_23060077_IMEM_MISALIGN_CHK_EN: a misaligned pc also raises an access fault.
//   state | meaning
//   IDLE  | ready to accept a fetch
//   WAIT  | latency down-counter running
//   RESP  | response held until rsp_ready
`include "ysyx_23060077_riscv_define.v"

module ysyx_23060077_riscv_imem
  import ysyx_23060077_riscv_imem_pkg::*;
#(
  parameter  int DEPTH   = 1024,
  parameter  int LATENCY = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060077_riscv_imem_if.slave bus,
  input  logic                     ld_en,
  input  logic [AW-1:0]            ld_addr,
  input  logic [31:0]              ld_data
);

  localparam logic [`DATA_WIDTH-1:0] ADDR_LIMIT = 4 * DEPTH;
  localparam logic [IMEM_CNT_W-1:0]  CNT_LOAD   = IMEM_CNT_W'(LATENCY - 1);

  imem_state_e           state;
  logic [IMEM_CNT_W-1:0] cnt;
  logic [AW-1:0]         idx_q;
  logic                  fault_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  req_fault;
  logic                  rd_en;
  logic [31:0]           rd_data;

  always_comb begin
    req_fault = (bus.req_addr >= ADDR_LIMIT);
`ifdef YSYX_23060077_IMEM_MISALIGN_CHK_EN
    if (bus.req_addr[1:0] != 2'b00) req_fault = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      fault_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            idx_q       <= bus.req_addr[AW+1:2];
            fault_q     <= req_fault;
            cnt         <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= fault_q;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  // A faulted request never touches the array, so out-of-range indices are never read.
  assign rd_en = (state == ST_WAIT) && (cnt == '0) && !fault_q;

  ysyx_23060077_riscv_imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ld_en && !rst),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .re      (rd_en),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_inst  = rsp_err_q ? IMEM_NOP_WORD : rd_data;

endmodule

// File: tb/tb_ysyx_23060077_riscv_imem.sv
// Bench for ysyx_23060077_riscv_imem: LATENCY=1 and LATENCY=4 instances against a word-array model.
module tb_ysyx_23060077_riscv_imem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_valid   [2];
  logic [31:0] req_addr    [2];
  logic        rsp_ready   [2];
  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic [31:0] rsp_inst_o  [2];
  logic        rsp_err_o   [2];

  int          lat_of [2];
  logic [31:0] mem_m  [DEPTH];
  int          n_assert = 0;
  int          n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060077_riscv_imem_if bus0 ();
  ysyx_23060077_riscv_imem_if bus1 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.rsp_ready = rsp_ready[1];

  assign req_ready_o[0] = bus0.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_inst_o[0]  = bus0.rsp_inst;
  assign rsp_err_o[0]   = bus0.rsp_err;
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_inst_o[1]  = bus1.rsp_inst;
  assign rsp_err_o[1]   = bus1.rsp_err;

  ysyx_23060077_riscv_imem #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus0),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  ysyx_23060077_riscv_imem #(.DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {err, inst} for a fetch from the current model memory.
  function automatic logic [32:0] model_rsp(input logic [31:0] a);
    if (a >= 32'(4 * DEPTH)) return {1'b1, NOP};
`ifdef YSYX_23060077_IMEM_MISALIGN_CHK_EN
    if (a[1:0] != 2'b00) return {1'b1, NOP};
`endif
    return {1'b0, mem_m[a[11:2]]};
  endfunction

  task automatic check_reset_state(input int k);
    chk("rst_ready", 32'(req_ready_o[k]), 32'd1);
    chk("rst_valid", 32'(rsp_valid_o[k]), 32'd0);
    chk("rst_err",   32'(rsp_err_o[k]),   32'd0);
    chk("rst_inst",  rsp_inst_o[k],       32'd0);
  endtask

  // One fetch on instance k; optional preload write on edge ld_cyc after accept (-1 = none);
  // rsp_ready held low for 'hold' cycles once the response is up.
  task automatic fetch(input int k, input logic [31:0] addr, input int hold,
                       input int ld_cyc, input logic [9:0] ld_idx, input logic [31:0] ld_val);
    logic [32:0] exp;
    logic [31:0] held;
    int          cyc;
    bit          got;
    chk("ready_idle", 32'(req_ready_o[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    rsp_ready[k] = (hold == 0);
    tick();
    req_valid[k] = 1'b0;
    chk("ready_busy", 32'(req_ready_o[k]), 32'd0);
    cyc = 0;
    got = 1'b0;
    exp = '0;
    while (!got && cyc < 40) begin
      if (cyc == lat_of[k] - 1) exp = model_rsp(addr);
      if (cyc + 1 == ld_cyc) begin
        ld_en   = 1'b1;
        ld_addr = ld_idx;
        ld_data = ld_val;
      end
      tick();
      cyc++;
      if (ld_en) begin
        ld_en = 1'b0;
        mem_m[ld_idx] = ld_val;
      end
      if (rsp_valid_o[k]) got = 1'b1;
      else chk("ready_wait", 32'(req_ready_o[k]), 32'd0);
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency",  32'(cyc), 32'(lat_of[k]));
    chk("rsp_err",  32'(rsp_err_o[k]), 32'(exp[32]));
    chk("rsp_inst", rsp_inst_o[k], exp[31:0]);
    chk("ready_resp", 32'(req_ready_o[k]), 32'd0);
    held = rsp_inst_o[k];
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        req_valid[k] = 1'b1;
        req_addr[k]  = $urandom & 32'h0000_0ffc;
      end
      tick();
      chk("hold_valid", 32'(rsp_valid_o[k]), 32'd1);
      chk("hold_inst",  rsp_inst_o[k], held);
      chk("hold_ready", 32'(req_ready_o[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    tick();
    chk("done_valid", 32'(rsp_valid_o[k]), 32'd0);
    chk("done_err",   32'(rsp_err_o[k]),   32'd0);
    chk("done_ready", 32'(req_ready_o[k]), 32'd1);
    rsp_ready[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst     = 1'b1;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    lat_of  = '{1, 4};
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = '0;
      rsp_ready[k] = 1'b0;
    end
    tick();
    tick();
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      ld_en   = 1'b1;
      ld_addr = 10'(i);
      ld_data = (i == 3) ? 32'h0010_0093 : $urandom;
      mem_m[i] = ld_data;
      tick();
    end
    ld_en = 1'b0;

    fetch(0, 32'h0000_000C, 0, -1, '0, '0);
    chk("word3_literal", rsp_inst_o[0], 32'h0010_0093);
    fetch(1, 32'h0000_0000, 0, -1, '0, '0);
    fetch(0, 32'h0000_0104, 5, -1, '0, '0);
    fetch(0, 32'h0000_1000, 0, -1, '0, '0);
    fetch(1, 32'hFFFF_FFFC, 2, -1, '0, '0);
    fetch(1, 32'h0000_0FFC, 0, -1, '0, '0);
    fetch(0, 32'h0000_0002, 0, -1, '0, '0);
    fetch(1, 32'h0000_0002, 1, -1, '0, '0);

    fetch(1, 32'h0000_0040, 0, 2, 10'h010, $urandom);
    fetch(1, 32'h0000_0044, 0, 4, 10'h011, $urandom);
    fetch(0, 32'h0000_0044, 0, 1, 10'h011, $urandom);
    fetch(0, 32'h0000_0044, 0, -1, '0, '0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * DEPTH - 1));
      fetch(int'($urandom_range(0, 1)), a, int'($urandom_range(0, 3)), -1, '0, '0);
    end

    chk("ready_pre_rst", 32'(req_ready_o[1]), 32'd1);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0000_0008;
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    rst     = 1'b1;
    ld_en   = 1'b1;
    ld_addr = 10'd2;
    ld_data = ~mem_m[2];
    tick();
    rst   = 1'b0;
    ld_en = 1'b0;
    check_reset_state(0);
    check_reset_state(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_rsp_after_rst", 32'(rsp_valid_o[1]), 32'd0);
    end
    fetch(1, 32'h0000_0008, 0, -1, '0, '0);
    fetch(0, 32'h0000_000C, 0, -1, '0, '0);
    chk("word3_after_rst", rsp_inst_o[0], 32'h0010_0093);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
